ddr2_ex_lfsr_read_checker: RTL and testbench
============================================

// Module: ddr2_ex_lfsr_read_checker
// PURPOSE
//  Read-data checker for the DDR2 example traffic driver; sits downstream of the 8-bit LFSR write-pattern generators.
//  Regenerates the expected pattern with one local LFSR per byte lane and compares it against returned read data.
//  Reports pass/fail, a saturating error count and sticky per-lane error flags to the driver control FSM.
//  Polynomial x^8+x^4+x^3+x^2+1, step: n0=s7 n1=s0 n2=s1^s7 n3=s2^s7 n4=s3^s7 n5=s4 n6=s5 n7=s6.
// PARAMETERS
//  DATA_BYTES  4   byte lanes; rdata width = 8*DATA_BYTES
//  SEED        32  lane i LFSR seed = (SEED+i) mod 256; must match the generator seeds
//  ERR_CNT_W   16  width of err_count
// PORTS
//  clk            in   1              clock
//  reset_n        in   1              reset, asynchronous, active-low
//  enable         in   1              0 = synchronously hold block in IDLE, LFSRs at seed
//  start          in   1              1-cycle pulse: (re)arm a check run
//  cfg_num_words  in   16             words expected in the run; sampled on start
//  rdata_valid    in   1              rdata qualifier
//  rdata          in   8*DATA_BYTES   read data; lane i = rdata[8i+7:8i]
//  busy           out  1              state==CHECK
//  done           out  1              run finished; held until start or enable=0
//  pass           out  1              done & no error
//  fail           out  1              done & (err_count!=0 | unexpected)
//  err_count      out  ERR_CNT_W      mismatching words, saturating at all-ones
//  lane_err       out  DATA_BYTES     sticky per-lane mismatch flags
//  first_err_idx  out  16             word index of first mismatch (option)
//  first_err_exp  out  8*DATA_BYTES   expected data of first mismatch (option)
//  first_err_act  out  8*DATA_BYTES   actual data of first mismatch (option)
// BEHAVIOUR
//  - Reset: state IDLE, LFSRs at seed, all outputs and internal counters 0.
//  - FSM IDLE->CHECK on start&enable (cfg_num_words!=0); IDLE->DONE directly if cfg_num_words==0 (pass=1 after that edge).
//  - start in any state with enable=1: reload seeds, words_left=cfg_num_words, clear err_count/lane_err/unexpected/capture.
//  - CHECK, rdata_valid=1: compare every lane vs its LFSR, step all LFSRs, words_left--, word_idx++.
//  - Compare is pipelined: edge E samples word into stage-1 mismatch vector + last flag;
//    edge E+1 ORs vector into lane_err, err_count +1 if any lane mismatches (once per word, not per lane).
//  - Last word sampled at edge E: state->DONE at edge E+1; done/pass/fail valid after E+1 (2 edges after sample).
//  - rdata_valid=0 in CHECK: LFSRs and counters hold (pause); no timeout in this block.
//  - rdata_valid in IDLE ignored; in DONE sets sticky unexpected -> fail=1, pass=0.
//  - start and rdata_valid in same cycle: start wins, that data word discarded.
//  - err_count saturates; no wrap. word_idx wraps at 16 bits (not reachable with 16-bit cfg).
//  - enable=0: next edge -> IDLE, LFSRs to seed, all outputs and pipeline cleared; start ignored.
//  - reset_n low mid-run: immediate async clear, identical to reset state.
// CONFIGURATION
//  DDR2_EX_FIRST_ERR_CAPTURE_EN defined: on first mismatching word of a run latch word index, expected and actual data
//   into first_err_*; later mismatches do not overwrite; cleared by start/enable=0/reset.
//  Not defined: capture logic not built; first_err_* tied to 0. All other behaviour identical.
// TESTING
//  1 DATA_BYTES=1 SEED=32 cfg=4, rdata 0x20,0x40,0x80,0x1D -> done 2 edges after last, pass=1, err_count=0.
//  2 As 1, third word 0x81 -> fail=1, err_count=1, lane_err=1; with _EN: idx=2 exp=0x80 act=0x81.
//  3 DATA_BYTES=4, cfg=3, gaps of 0-3 idle cycles between valids, correct data -> pass=1, LFSRs paused correctly.
//  4 cfg=0 start -> done=1, pass=1 on next edge; rdata_valid afterwards -> fail=1.
//  5 ERR_CNT_W=2, cfg=8, every word wrong -> err_count=3 (saturated), fail=1.
//  6 enable=0 mid-run -> IDLE, outputs 0 next edge; start+rdata_valid same cycle in CHECK -> restart, word ignored.

Source files
------------

// File: rtl/ddr2_ex_lfsr_read_checker.sv
`default_nettype none
// ============================================================================
// ddr2_ex_lfsr_read_checker: per-lane LFSR read-data checker with pass/fail and
// error stats; define DDR2_EX_FIRST_ERR_CAPTURE_EN for first-error capture.
// Revision: 1.0
// ============================================================================
module ddr2_ex_lfsr_read_checker #(
  parameter int DATA_BYTES = 4,
  parameter int SEED       = 32,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    start,
  input  logic [15:0]             cfg_num_words,
  input  logic                    rdata_valid,
  input  logic [8*DATA_BYTES-1:0] rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic [ERR_CNT_W-1:0]    err_count,
  output logic [DATA_BYTES-1:0]   lane_err,
  output logic [15:0]             first_err_idx,
  output logic [8*DATA_BYTES-1:0] first_err_exp,
  output logic [8*DATA_BYTES-1:0] first_err_act
);

  localparam int W = 8 * DATA_BYTES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic                  rearm;
  logic                  sample;
  logic [15:0]           words_left;
  logic [W-1:0]          expected;
  logic [DATA_BYTES-1:0] mismatch;
  logic                  s1_valid;
  logic                  s1_last;
  logic [DATA_BYTES-1:0] s1_mis;
  logic                  unexpected;

  // x^8+x^4+x^3+x^2+1, must track the write-pattern generators exactly
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6], s[5], s[4], s[3] ^ s[7], s[2] ^ s[7], s[1] ^ s[7], s[0], s[7]};
  endfunction

  // Disable or start both return the block to seed state
  assign rearm  = !enable || start;
  assign sample = enable && !start && (state == CHECK) && rdata_valid && (words_left != 16'd0);

  for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
    localparam logic [7:0] LANE_SEED = 8'((SEED + i) % 256);
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    lfsr <= LANE_SEED;
      else if (rearm)  lfsr <= LANE_SEED;
      else if (sample) lfsr <= lfsr_step(lfsr);
    end

    assign expected[8*i +: 8] = lfsr;
    assign mismatch[i]        = (rdata[8*i +: 8] != lfsr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
    end else if (start) begin
      state_nx = (cfg_num_words == 16'd0) ? DONE : CHECK;
    end else if (state == CHECK && s1_valid && s1_last) begin
      state_nx = DONE;
    end
    busy = (state == CHECK);
    done = (state == DONE);
  end

  assign pass = done && (err_count == '0) && !unexpected;
  assign fail = done && ((err_count != '0) || unexpected);

  // Stage 1 registers the per-lane compare; stage 2 folds it into the stats
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_left <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_mis     <= '0;
      err_count  <= '0;
      lane_err   <= '0;
      unexpected <= 1'b0;
    end else if (rearm) begin
      words_left <= enable ? cfg_num_words : 16'd0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_mis     <= '0;
      err_count  <= '0;
      lane_err   <= '0;
      unexpected <= 1'b0;
    end else begin
      s1_valid <= sample;
      if (sample) begin
        s1_mis     <= mismatch;
        s1_last    <= (words_left == 16'd1);
        words_left <= words_left - 16'd1;
      end
      if (s1_valid) begin
        lane_err <= lane_err | s1_mis;
        if ((|s1_mis) && (err_count != '1)) err_count <= err_count + 1'b1;
      end
      if (state == DONE && rdata_valid) unexpected <= 1'b1;
    end
  end

`ifdef DDR2_EX_FIRST_ERR_CAPTURE_EN
  logic [15:0]  word_idx;
  logic [15:0]  s1_idx;
  logic [W-1:0] s1_exp;
  logic [W-1:0] s1_act;
  logic         captured;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_idx      <= '0;
      s1_idx        <= '0;
      s1_exp        <= '0;
      s1_act        <= '0;
      captured      <= 1'b0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
    end else if (rearm) begin
      word_idx      <= '0;
      s1_idx        <= '0;
      s1_exp        <= '0;
      s1_act        <= '0;
      captured      <= 1'b0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
    end else begin
      if (sample) begin
        word_idx <= word_idx + 16'd1;
        s1_idx   <= word_idx;
        s1_exp   <= expected;
        s1_act   <= rdata;
      end
      if (s1_valid && (|s1_mis) && !captured) begin
        captured      <= 1'b1;
        first_err_idx <= s1_idx;
        first_err_exp <= s1_exp;
        first_err_act <= s1_act;
      end
    end
  end
`else
  assign first_err_idx = '0;
  assign first_err_exp = '0;
  assign first_err_act = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr2_ex_lfsr_read_checker.sv
`default_nettype none
// Directed bench for ddr2_ex_lfsr_read_checker: a scoreboard holds the expected
// run outcome, popped and compared when the checker reports done.
module tb_ddr2_ex_lfsr_read_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg = '0;
  logic        rdata_valid = 1'b0;
  logic [31:0] rdata = '0;
  logic        busy, done, pass, fail;
  logic [1:0]  err_count;
  logic [3:0]  lane_err;
  logic [15:0] first_err_idx;
  logic [31:0] first_err_exp, first_err_act;

  ddr2_ex_lfsr_read_checker #(.DATA_BYTES(4), .SEED(32), .ERR_CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start),
    .cfg_num_words(cfg), .rdata_valid(rdata_valid), .rdata(rdata),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .err_count(err_count), .lane_err(lane_err), .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp), .first_err_act(first_err_act)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pass;
    logic        fail;
    logic [1:0]  ec;
    logic [3:0]  le;
    logic [15:0] idx;
    logic [31:0] exp;
    logic [31:0] act;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  int         cur_errs;
  bit         cur_cap;
  int         widx;
  logic [7:0] mdl[4];
  int         compares = 0;
  int         fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Galois form of the same polynomial
  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_seed(input string tag);
    for (int i = 0; i < 4; i++) mdl[i] = 8'(32 + i);
    cur.tag = tag; cur.pass = 1'b0; cur.fail = 1'b0; cur.ec = '0; cur.le = '0;
    cur.idx = '0; cur.exp = '0; cur.act = '0;
    cur_errs = 0; cur_cap = 1'b0; widx = 0;
  endtask

  task automatic do_start(input logic [15:0] n, input string tag);
    model_seed(tag);
    start = 1'b1; cfg = n;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run();
    exp_t e;
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({e.tag, "_pass"}, pass, e.pass);
    check({e.tag, "_fail"}, fail, e.fail);
    check({e.tag, "_err_count"}, err_count, e.ec);
    check({e.tag, "_lane_err"}, lane_err, e.le);
    check({e.tag, "_busy"}, busy, 1'b0);
`ifdef DDR2_EX_FIRST_ERR_CAPTURE_EN
    check({e.tag, "_idx"}, first_err_idx, e.idx);
    check({e.tag, "_exp"}, first_err_exp, e.exp);
    check({e.tag, "_act"}, first_err_act, e.act);
`else
    check({e.tag, "_cap_tied"}, {first_err_idx, first_err_exp, first_err_act} != '0, 1'b0);
`endif
  endtask

  task automatic send(input logic [31:0] xmask, input int gap, input bit last);
    logic [31:0] e, d;
    repeat (gap) tick();
    e = {mdl[3], mdl[2], mdl[1], mdl[0]};
    d = e ^ xmask;
    if (xmask != 0) begin
      for (int i = 0; i < 4; i++) if (xmask[8*i +: 8] != 8'h00) cur.le[i] = 1'b1;
      if (!cur_cap) begin
        cur_cap = 1'b1; cur.idx = 16'(widx); cur.exp = e; cur.act = d;
      end
      cur_errs++;
    end
    for (int i = 0; i < 4; i++) mdl[i] = nxt(mdl[i]);
    widx++;
    rdata_valid = 1'b1; rdata = d;
    tick();
    rdata_valid = 1'b0;
    if (last) begin
      cur.ec   = (cur_errs > 3) ? 2'd3 : 2'(cur_errs);
      cur.pass = (cur_errs == 0);
      cur.fail = (cur_errs != 0);
      sb.push_back(cur);
      check({cur.tag, "_done_early"}, done, 1'b0);
      tick();
      check({cur.tag, "_done"}, done, 1'b1);
      finish_run();
    end
  endtask

  initial begin
    // reset state
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_passfail", {pass, fail}, 2'b00);
    check("rst_err_count", err_count, 2'd0);
    check("rst_lane_err", lane_err, 4'd0);
    check("rst_cap", {first_err_idx, first_err_exp, first_err_act} != '0, 1'b0);
    reset_n = 1'b1; enable = 1'b1;
    tick();

    // 1: clean run, words 0x20,0x40,0x80,0x1D on lane 0
    do_start(16'd4, "t1");
    check("t1_busy", busy, 1'b1);
    check("t1_word0", {mdl[3], mdl[2], mdl[1], mdl[0]}, 32'h23222120);
    send('0, 0, 0); send('0, 0, 0); send('0, 0, 0); send('0, 0, 1);

    // 2: third word lane0 0x80 -> 0x81
    do_start(16'd4, "t2");
    send('0, 0, 0); send('0, 0, 0); send(32'h0000_0001, 0, 0); send('0, 0, 1);

    // 3: idle gaps between valids
    do_start(16'd3, "t3");
    send('0, 0, 0); send('0, 3, 0); send('0, int'($urandom_range(1, 2)), 1);

    // 4: zero-length run, then unexpected data
    do_start(16'd0, "t4");
    check("t4_done", done, 1'b1);
    check("t4_pass", pass, 1'b1);
    rdata_valid = 1'b1; rdata = 32'h1234_5678;
    tick();
    rdata_valid = 1'b0;
    check("t4_unexp_fail", fail, 1'b1);
    check("t4_unexp_pass", pass, 1'b0);

    // 5: every word wrong, err_count saturates at 3
    do_start(16'd8, "t5");
    for (int k = 0; k < 8; k++) send(32'h8000_0001, k % 2, k == 7);

    // 6a: enable drop mid-run clears everything, including in-flight error
    do_start(16'd4, "t6a");
    send(32'h0000_0100, 0, 0);
    enable = 1'b0;
    tick();
    check("t6a_busy", busy, 1'b0);
    check("t6a_done", done, 1'b0);
    check("t6a_err_count", err_count, 2'd0);
    check("t6a_lane_err", lane_err, 4'd0);
    enable = 1'b1;

    // 6b: start with rdata_valid in CHECK restarts and drops the word
    do_start(16'd2, "t6b");
    send('0, 0, 0);
    model_seed("t6b");
    start = 1'b1; cfg = 16'd2; rdata_valid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; rdata_valid = 1'b0;
    check("t6b_busy", busy, 1'b1);
    send('0, 0, 0); send('0, 0, 1);

    // asynchronous reset mid-run
    do_start(16'd4, "t7");
    send(32'h0001_0000, 0, 0);
    tick();
    check("t7_err_before", err_count, 2'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t7_async_busy", busy, 1'b0);
    check("t7_async_err", err_count, 2'd0);
    check("t7_async_lane", lane_err, 4'd0);
    #1 reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
`default_nettype wire
